// File: rtl/imm_extend_unit.sv
// Immediate-generation stage between decode and execute.
// Turns the raw immediate/jump field into a full-width operand
// (sign-extend, zero-extend, LUI, branch offset, jump target) and holds
// results in a 2-entry buffer behind valid/ready handshakes. The head
// entry drives the outputs and the tail entry is the skid slot.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int JMP_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [JMP_W-1:0] imm_in,
  input  logic [OUT_W-1:0] pc_plus4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             mode_err
);

  localparam logic [2:0] MODE_SEXT   = 3'd0;
  localparam logic [2:0] MODE_ZEXT   = 3'd1;
  localparam logic [2:0] MODE_LUI    = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_JUMP   = 3'd4;

  logic [IN_W-1:0]  w_field;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_lui;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_jump;
  logic [OUT_W-1:0] w_result;
  logic             w_err;

  assign w_field  = imm_in[IN_W-1:0];
  assign w_sext   = {{(OUT_W-IN_W){w_field[IN_W-1]}}, w_field};
  assign w_zext   = {{(OUT_W-IN_W){1'b0}}, w_field};
  assign w_lui    = {w_field, {(OUT_W-IN_W){1'b0}}};
  assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

  // The upper PC region vanishes when the jump field fills the whole operand.
  generate
    if (OUT_W > JMP_W + 2) begin : g_jump_pc
      logic w_unused_pc;
      assign w_jump      = {pc_plus4[OUT_W-1:JMP_W+2], imm_in, 2'b00};
      assign w_unused_pc = ^pc_plus4[JMP_W+1:0];
    end else begin : g_jump_nopc
      logic w_unused_pc;
      assign w_jump      = {imm_in, 2'b00};
      assign w_unused_pc = ^pc_plus4;
    end
  endgenerate

  // Select the operand for the requested mode; illegal modes yield zero with an error flag.
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (mode)
      MODE_SEXT:   w_result = w_sext;
      MODE_ZEXT:   w_result = w_zext;
      MODE_LUI:    w_result = w_lui;
      MODE_BRANCH: w_result = w_branch;
      MODE_JUMP:   w_result = w_jump;
      default:     w_err    = 1'b1;
    endcase
  end

  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_head_data;
  logic             r_head_err;
  logic [OUT_W-1:0] r_tail_data;
  logic             r_tail_err;

  logic       w_accept;
  logic       w_consume;
  logic [1:0] w_count_nxt;

  assign out_valid = (r_count != 2'd0);
  assign in_ready  = r_in_ready;
  assign imm_out   = r_head_data;
  assign mode_err  = r_head_err;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = out_valid & out_ready;

  // Occupancy after this edge's accept/consume pair.
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_consume)
      w_count_nxt = r_count + 2'd1;
    else if (!w_accept && w_consume)
      w_count_nxt = r_count - 2'd1;
  end

  // Occupancy and a registered ready, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Head loads straight from the input when it is (or is becoming) free, else refills from the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_err  <= 1'b0;
    end else if (w_accept && ((r_count == 2'd0) || ((r_count == 2'd1) && w_consume))) begin
      r_head_data <= w_result;
      r_head_err  <= w_err;
    end else if (w_consume && (r_count == 2'd2)) begin
      r_head_data <= r_tail_data;
      r_head_err  <= r_tail_err;
    end
  end

  // Skid slot captures a request that arrives while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_data <= '0;
      r_tail_err  <= 1'b0;
    end else if (w_accept && (r_count == 2'd1) && !w_consume) begin
      r_tail_data <= w_result;
      r_tail_err  <= w_err;
    end
  end

endmodule
